// File: rtl/sorted_record_queue.sv
// sorted_record_queue: sorted register-array priority queue, minimum key at entry[0], FIFO among equal keys.
// Define MIN_DUP_COUNT_EN to add the min_dup_count output.
module sorted_record_queue #(
  parameter int RECORD_WIDTH = 48,
  parameter int KEY_WIDTH    = 32,
  parameter int KEY_LSB      = 16,
  parameter int DEPTH        = 8,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    push_to_ram,
  input  logic [RECORD_WIDTH-1:0] record_to_push,
  input  logic                    pop_from_ram,
  output logic                    ready,
  output logic [RECORD_WIDTH-1:0] min_record,
  output logic                    min_valid,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow
`ifdef MIN_DUP_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]  min_dup_count
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, SETTLE} state_t;
  typedef enum logic [1:0] {OP_INS, OP_REM, OP_REP} op_t;
  state_t state, state_nxt;
  op_t op;
  logic [RECORD_WIDTH-1:0] rec;
  logic [RECORD_WIDTH-1:0] entry [DEPTH];
  logic [RECORD_WIDTH-1:0] rem [DEPTH];
  logic [RECORD_WIDTH-1:0] base [DEPTH];
  logic [RECORD_WIDTH-1:0] nxt [DEPTH];
  logic [COUNT_WIDTH-1:0] bcnt, pos, cnt_nxt;
  logic accept;
  function automatic logic [KEY_WIDTH-1:0] key_of(input logic [RECORD_WIDTH-1:0] r);
    return r[KEY_LSB +: KEY_WIDTH];
  endfunction
  assign ready  = state == IDLE;
  assign full   = count == COUNT_WIDTH'(DEPTH);
  assign empty  = count == '0;
  assign accept = (push_to_ram && pop_from_ram) || (push_to_ram && !full) || (pop_from_ram && !empty);
  always_comb begin
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? SETTLE : IDLE;
  end
  // REPLACE inserts into the already-shifted array, so both ops resolve in one edge.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) rem[i] = entry[i+1];
    rem[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) base[i] = op == OP_INS ? entry[i] : rem[i];
    bcnt = op == OP_INS ? count : count - COUNT_WIDTH'(1);
    pos = bcnt;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (COUNT_WIDTH'(i) < bcnt && key_of(base[i]) > key_of(rec)) pos = COUNT_WIDTH'(i);
    nxt[0] = pos == '0 ? rec : base[0];
    for (int i = 1; i < DEPTH; i++)
      nxt[i] = COUNT_WIDTH'(i) < pos ? base[i] : COUNT_WIDTH'(i) == pos ? rec : base[i-1];
    cnt_nxt = op == OP_REM ? bcnt : bcnt + COUNT_WIDTH'(1);
  end
`ifdef MIN_DUP_COUNT_EN
  logic [COUNT_WIDTH-1:0] dup;
  always_comb begin
    dup = '0;
    for (int i = 0; i < DEPTH; i++)
      if (COUNT_WIDTH'(i) < count && key_of(entry[i]) == key_of(entry[0])) dup = dup + COUNT_WIDTH'(1);
  end
`endif
  always_ff @(posedge clk) state <= !rst_b ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      op         <= OP_INS;
      rec        <= '0;
      count      <= '0;
      min_record <= '0;
      min_valid  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
`ifdef MIN_DUP_COUNT_EN
      min_dup_count <= '0;
`endif
    end else begin
      overflow  <= state == IDLE && push_to_ram && !pop_from_ram && full;
      underflow <= state == IDLE && pop_from_ram && empty;
      if (state == IDLE && accept) begin
        op        <= push_to_ram && pop_from_ram && !empty ? OP_REP : push_to_ram ? OP_INS : OP_REM;
        rec       <= record_to_push;
        min_valid <= 1'b0;
      end
      if (state == EXEC) begin
        for (int i = 0; i < DEPTH; i++) entry[i] <= op == OP_REM ? base[i] : nxt[i];
        count <= cnt_nxt;
      end
      if (state == SETTLE) begin
        min_record <= entry[0];
        min_valid  <= count != '0;
`ifdef MIN_DUP_COUNT_EN
        min_dup_count <= dup;
`endif
      end
    end
  end
endmodule

// File: doc/sorted_record_queue.md
Name: sorted_record_queue

Overview:
- Parametrised successor to the single-configuration RAM record manager: a sorted register-array priority queue holding up to DEPTH records.
- Keeps the record with the minimum key at the head, with FIFO order among equal keys (multikey handling).
- Exposes the head record with a valid flag.
- Sits between the record producer (push side) and the consumer draining minimum-key records (pop side).

Parameters:
RECORD_WIDTH, 48, total record width in bits
KEY_WIDTH, 32, width of the key field, compared as unsigned
KEY_LSB, 16, bit position of the key LSB within the record; KEY_LSB+KEY_WIDTH <= RECORD_WIDTH
DEPTH, 8, number of record slots (>= 2)
COUNT_WIDTH, 4, width of the occupancy count; 2**COUNT_WIDTH > DEPTH

Ports:
clk  input  1  rising-edge clock
rst_b  input  1  synchronous active-low reset
push_to_ram  input  1  push request, sampled only while ready=1
record_to_push  input  RECORD_WIDTH  record to insert, sampled with push_to_ram
pop_from_ram  input  1  pop request (remove head), sampled only while ready=1
ready  output  1  high when a request can be accepted (state IDLE)
min_record  output  RECORD_WIDTH  head record (minimum key); meaningful only when min_valid=1
min_valid  output  1  head record valid
count  output  COUNT_WIDTH  number of stored records
full  output  1  count==DEPTH
empty  output  1  count==0
overflow  output  1  one-cycle pulse: push rejected because full
underflow  output  1  one-cycle pulse: pop requested while empty

Behaviour:
- Key of a record: record[KEY_LSB+KEY_WIDTH-1:KEY_LSB]. Slots entry[0..DEPTH-1]; entry[0] is the head. Invariant: entries 0..count-1 are ascending by key.
- A new record goes after all existing records with an equal key.
- Reset (rst_b=0 at a clock edge): state=IDLE, count=0, all entries=0, min_record=0, min_valid=0, overflow=0, underflow=0, ready=1. Reset mid-operation aborts the operation; no partial shift survives.
- FSM states IDLE, EXEC, SETTLE. ready = (state==IDLE).
- IDLE, request accepted at edge T: latch the op and record, min_valid<=0, state<=EXEC. Op types:
  - push only → INSERT.
  - pop only → REMOVE.
  - both → REPLACE: remove head and insert the new record; count unchanged.
- IDLE with no request: stay, outputs hold.
- EXEC (edge T+1):
  - INSERT: position p = first index with key > new key (p=count if none); entries p..count-1 shift up one; entry[p]=new; count+1.
  - REMOVE: entries shift down one; vacated top slot zeroed; count-1.
  - REPLACE: remove then insert, computed combinationally from the pre-op array in one edge.
  - state<=SETTLE.
- SETTLE (edge T+2): min_record<=entry[0], min_valid<=(count!=0), state<=IDLE. ready and min_valid are high again from cycle T+3.
- Throughput: one op per 3 cycles. Inputs are ignored while ready=0.
- Push while full, pop=0: rejected at acceptance; overflow=1 for one cycle; stay IDLE; array, count and min_valid unchanged.
- Pop while empty, push=0: underflow=1 for one cycle; stay IDLE; nothing else changes.
- Push and pop while empty: executes as INSERT; underflow pulses.
- Push and pop while full: REPLACE proceeds; no overflow.
- full, empty and count update at edge T+1 (EXEC).

Optional Feature:
- Macro MIN_DUP_COUNT_EN.
- Defined: adds output min_dup_count [COUNT_WIDTH-1:0]. It is loaded in SETTLE with the number of stored entries whose key equals the entry[0] key, and is 0 when empty. Valid when min_valid=1; reset value 0.
- Not defined: the port and its compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push keys 0x30, 0x10, 0x20 (values 0xA,0xB,0xC), each waiting for ready → after the final SETTLE, min_record key=0x10 value 0xB, count=3, min_valid=1. Each op drops min_valid for exactly 2 cycles.
- Continue with 3 pops → heads observed 0x20/0xC, then 0x30/0xA, then empty=1, min_valid=0. A further pop gives a 1-cycle underflow; count stays 0.
- Push 8 records with key 0x5 (values 1..8) into DEPTH=8 → full=1. A 9th push gives a 1-cycle overflow and no change. Pops return values 1..8 in order (FIFO among equal keys). With MIN_DUP_COUNT_EN: min_dup_count=8, then 7, and so on.
- Full queue (keys 1..8): push key 0x4 together with pop → REPLACE. Head becomes key 2, count stays 8, no overflow, and subsequent pops yield 2,3,4,4,5,6,7,8.
- Empty queue: push key 0x7 together with pop → count=1, head key 0x7, underflow pulses once.
- Assert rst_b=0 during EXEC of a push into a 3-entry queue → next cycle count=0, min_valid=0, ready=1, entries 0. A subsequent push key 0x9 makes it the head.
